// File: rtl/execute_cycle_simd.sv
// Execute stage of the 256-bit SIMD FIR pipeline: lane-wise ALU, branch resolve, multi-cycle mul/mac.
// Define SATURATE_EN to make add/sub/mul/mac saturate per lane instead of wrapping.
module execute_cycle_simd #(
    parameter int LANES          = 16,
    parameter int LANE_W         = 16,
    parameter int MULS_PER_CYCLE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWriteE,
    input  logic                      MemWriteE,
    input  logic                      BranchE,
    input  logic                      ALUSrcE,
    input  logic                      ResultSrcE,
    input  logic [2:0]                ALUControlE,
    input  logic [LANES*LANE_W-1:0]   RD1E,
    input  logic [LANES*LANE_W-1:0]   RD2E,
    input  logic [LANES*LANE_W-1:0]   ImmExtE,
    input  logic [LANES*LANE_W-1:0]   PCE,
    input  logic [LANES*LANE_W-1:0]   PCPlus4E,
    input  logic [4:0]                RDE,
    output logic                      StallE,
    output logic                      PCSrcE,
    output logic [LANES*LANE_W-1:0]   PCTargetE,
    output logic                      RegWriteM,
    output logic                      MemWriteM,
    output logic                      ResultSrcM,
    output logic [LANES*LANE_W-1:0]   ALUResultM,
    output logic [LANES*LANE_W-1:0]   WriteDataM,
    output logic [LANES*LANE_W-1:0]   PCPlus4M,
    output logic [4:0]                RDM
);
    localparam int W  = LANES * LANE_W;
    localparam int N  = LANES / MULS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * LANE_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [LANE_W-1:0] acc_q, acc_d;
    logic [W-1:0]      a_q, b_q, wd_q, pc4_q, mres_q, mres_d;
    logic [4:0]        rd_q;
    logic              mac_q, mw_q, rs_q;

    logic              rw_m_q, mw_m_q, rs_m_q;
    logic [W-1:0]      alu_m_q, wd_m_q, pc4_m_q;
    logic [4:0]        rd_m_q;

    logic [W-1:0]      src_b, sc_res, fin_res;
    logic              zero, start;
    int                mc_idx;
    logic [LANE_W-1:0] mc_prod;

    function automatic logic signed [PW-1:0] sext(input logic [LANE_W-1:0] v);
        sext = {{LANE_W{v[LANE_W-1]}}, v};
    endfunction

    // Reduce a double-width signed value to one lane, clamping or wrapping.
    function automatic logic [LANE_W-1:0] fit(input logic signed [PW-1:0] v);
`ifdef SATURATE_EN
        logic signed [PW-1:0] smax, smin;
        smax = (PW'(1) <<< (LANE_W - 1)) - PW'(1);
        smin = -(PW'(1) <<< (LANE_W - 1));
        if (v > smax)      fit = smax[LANE_W-1:0];
        else if (v < smin) fit = smin[LANE_W-1:0];
        else               fit = v[LANE_W-1:0];
`else
        fit = v[LANE_W-1:0];
`endif
    endfunction

    function automatic logic [LANE_W-1:0] lane_alu(input logic [2:0] op,
                                                   input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
        case (op)
            3'b000:  lane_alu = fit(sext(a) + sext(b));
            3'b001:  lane_alu = fit(sext(a) - sext(b));
            3'b010:  lane_alu = a & b;
            3'b011:  lane_alu = a | b;
            3'b101:  lane_alu = {{(LANE_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: lane_alu = '0;
        endcase
    endfunction

    always_comb begin
        src_b  = ALUSrcE ? ImmExtE : RD2E;
        sc_res = '0;
        for (int l = 0; l < LANES; l++) begin
            sc_res[l*LANE_W +: LANE_W] = lane_alu(ALUControlE, RD1E[l*LANE_W +: LANE_W],
                                                  src_b[l*LANE_W +: LANE_W]);
        end
    end

    assign zero      = (sc_res == '0);
    assign start     = (state_q == IDLE) && (ALUControlE[2:1] == 2'b11) && RegWriteE;
    assign StallE    = !rst && (start || ((state_q == BUSY) && (cnt_q != CW'(N - 1))));
    assign PCSrcE    = !rst && BranchE && zero && (state_q == IDLE);
    assign PCTargetE = PCE + ImmExtE;

    // One chunk of lane products per BUSY cycle; the mac sum folds in lane order.
    always_comb begin
        mres_d  = mres_q;
        acc_d   = acc_q;
        mc_idx  = 0;
        mc_prod = '0;
        for (int j = 0; j < MULS_PER_CYCLE; j++) begin
            mc_idx  = int'(cnt_q) * MULS_PER_CYCLE + j;
            mc_prod = fit(sext(a_q[mc_idx*LANE_W +: LANE_W]) * sext(b_q[mc_idx*LANE_W +: LANE_W]));
            mres_d[mc_idx*LANE_W +: LANE_W] = mc_prod;
            acc_d   = fit(sext(acc_d) + sext(mc_prod));
        end
        fin_res = mac_q ? {{(W-LANE_W){1'b0}}, acc_d} : mres_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            pc4_q   <= '0;
            mres_q  <= '0;
            rd_q    <= '0;
            mac_q   <= 1'b0;
            mw_q    <= 1'b0;
            rs_q    <= 1'b0;
            rw_m_q  <= 1'b0;
            mw_m_q  <= 1'b0;
            rs_m_q  <= 1'b0;
            alu_m_q <= '0;
            wd_m_q  <= '0;
            pc4_m_q <= '0;
            rd_m_q  <= '0;
        end else begin
            // Bubble by default; overridden when a real result retires.
            rw_m_q  <= 1'b0;
            mw_m_q  <= 1'b0;
            rs_m_q  <= 1'b0;
            alu_m_q <= '0;
            wd_m_q  <= '0;
            pc4_m_q <= '0;
            rd_m_q  <= '0;
            if (state_q == IDLE) begin
                if (start) begin
                    state_q <= BUSY;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    mres_q  <= '0;
                    a_q     <= RD1E;
                    b_q     <= src_b;
                    wd_q    <= RD2E;
                    pc4_q   <= PCPlus4E;
                    rd_q    <= RDE;
                    mac_q   <= ALUControlE[0];
                    mw_q    <= MemWriteE;
                    rs_q    <= ResultSrcE;
                end else begin
                    rw_m_q  <= RegWriteE;
                    mw_m_q  <= MemWriteE;
                    rs_m_q  <= ResultSrcE;
                    alu_m_q <= sc_res;
                    wd_m_q  <= RD2E;
                    pc4_m_q <= PCPlus4E;
                    rd_m_q  <= RDE;
                end
            end else begin
                acc_q  <= acc_d;
                mres_q <= mres_d;
                if (cnt_q == CW'(N - 1)) begin
                    state_q <= IDLE;
                    rw_m_q  <= 1'b1;
                    mw_m_q  <= mw_q;
                    rs_m_q  <= rs_q;
                    alu_m_q <= fin_res;
                    wd_m_q  <= wd_q;
                    pc4_m_q <= pc4_q;
                    rd_m_q  <= rd_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign RegWriteM  = rw_m_q;
    assign MemWriteM  = mw_m_q;
    assign ResultSrcM = rs_m_q;
    assign ALUResultM = alu_m_q;
    assign WriteDataM = wd_m_q;
    assign PCPlus4M   = pc4_m_q;
    assign RDM        = rd_m_q;
endmodule

// File: tb/tb_execute_cycle_simd.sv
// Self-checking bench for execute_cycle_simd: vector table for single-cycle ops, hand sequences for mul/mac/reset.
`timescale 1ns/1ps
module tb_execute_cycle_simd;
    localparam int W = 256;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE;
    logic [2:0]   ALUControlE;
    logic [W-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]   RDE;
    logic         StallE, PCSrcE;
    logic [W-1:0] PCTargetE;
    logic         RegWriteM, MemWriteM, ResultSrcM;
    logic [W-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]   RDM;

    always #5 clk = ~clk;

    execute_cycle_simd dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RDE(RDE), .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RDM(RDM)
    );

    typedef struct {
        logic [2:0]  op;
        logic        rw;
        logic        alusrc;
        logic        branch;
        logic [15:0] a, b, imm, exp;
        logic        exp_pcsrc;
    } vec_t;

    vec_t         vt[12];
    logic [W-1:0] exp_q[$];
    int           n_tot = 0;
    int           n_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic pop_chk(input string name);
        if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL %s: scoreboard empty, got %h", name, ALUResultM);
        end else begin
            chk(name, ALUResultM, exp_q.pop_front());
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [15:0] v);
        rep = {16{v}};
    endfunction

    function automatic logic [W-1:0] rnd256();
        rnd256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] mul_ref(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] p;
        p = $signed(x) * $signed(y);
`ifdef SATURATE_EN
        if (p > 32'sd32767)       mul_ref = 16'h7FFF;
        else if (p < -32'sd32768) mul_ref = 16'h8000;
        else                      mul_ref = p[15:0];
`else
        mul_ref = p[15:0];
`endif
    endfunction

    task automatic set_in(input logic [2:0] op, input logic rw, input logic alusrc, input logic branch,
                          input logic mw, input logic rs, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic [W-1:0] pc, input logic [4:0] rd);
        ALUControlE = op;  RegWriteE = rw;  ALUSrcE = alusrc;  BranchE = branch;
        MemWriteE   = mw;  ResultSrcE = rs; RD1E = a;  RD2E = b;  ImmExtE = imm;
        PCE = pc;  PCPlus4E = pc + W'(4);  RDE = rd;
    endtask

    task automatic sc_vec(input int i);
        logic [W-1:0] pc;
        logic [0:0]   mw, rs;
        pc = rnd256();
        mw = 1'(i);
        rs = 1'(i >> 1);
        set_in(vt[i].op, vt[i].rw, vt[i].alusrc, vt[i].branch, mw, rs,
               rep(vt[i].a), rep(vt[i].b), rep(vt[i].imm), pc, 5'(i + 1));
        #3;
        chk($sformatf("sc%0d_stall", i), StallE, 0);
        chk($sformatf("sc%0d_pcsrc", i), PCSrcE, vt[i].exp_pcsrc);
        chk($sformatf("sc%0d_target", i), PCTargetE, pc + rep(vt[i].imm));
        exp_q.push_back(rep(vt[i].exp));
        @(posedge clk); #1;
        pop_chk($sformatf("sc%0d_alu", i));
        chk($sformatf("sc%0d_rw", i), RegWriteM, vt[i].rw);
        chk($sformatf("sc%0d_mw", i), MemWriteM, mw);
        chk($sformatf("sc%0d_rs", i), ResultSrcM, rs);
        chk($sformatf("sc%0d_wd", i), WriteDataM, rep(vt[i].b));
        chk($sformatf("sc%0d_pc4", i), PCPlus4M, pc + W'(4));
        chk($sformatf("sc%0d_rd", i), RDM, 5'(i + 1));
    endtask

    task automatic run_mc(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] rd, input logic [W-1:0] exp);
        logic [W-1:0] pc, g;
        pc = rnd256();
        set_in(op, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a, b, rep(16'h0505), pc, rd);
        #3;
        chk({name, "_stall0"}, StallE, 1);
        exp_q.push_back(exp);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_bubble_rw%0d", name, k), RegWriteM, 0);
            chk($sformatf("%s_bubble_alu%0d", name, k), ALUResultM, 0);
            g = rnd256();
            set_in(($urandom_range(0, 1) != 0) ? 3'b001 : 3'b110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                   g, g, rnd256(), rnd256(), 5'($urandom_range(0, 31)));
            #2;
            chk($sformatf("%s_stall%0d", name, k), StallE, (k < N) ? 1 : 0);
            chk($sformatf("%s_busy_pcsrc%0d", name, k), PCSrcE, 0);
            chk($sformatf("%s_busy_target%0d", name, k), PCTargetE, PCE + ImmExtE);
        end
        @(posedge clk); #1;
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd0);
        pop_chk({name, "_result"});
        chk({name, "_rw"}, RegWriteM, 1);
        chk({name, "_rd"}, RDM, rd);
        chk({name, "_wd"}, WriteDataM, b);
        chk({name, "_rs"}, ResultSrcM, 1);
        chk({name, "_pc4"}, PCPlus4M, pc + W'(4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, rexp;
`ifdef SATURATE_EN
        vt[0] = '{3'b000, 1, 0, 1, 16'h7FFF, 16'h0001, 16'h0000, 16'h7FFF, 0};
        vt[3] = '{3'b001, 1, 0, 1, 16'h8000, 16'h0001, 16'h0000, 16'h8000, 0};
`else
        vt[0] = '{3'b000, 1, 0, 1, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 0};
        vt[3] = '{3'b001, 1, 0, 1, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 0};
`endif
        vt[1]  = '{3'b000, 1, 0, 1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1};
        vt[2]  = '{3'b001, 1, 0, 0, 16'h0005, 16'h0007, 16'h0000, 16'hFFFE, 0};
        vt[4]  = '{3'b010, 1, 0, 1, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h3030, 0};
        vt[5]  = '{3'b011, 1, 1, 0, 16'h00F0, 16'h1234, 16'h000F, 16'h00FF, 0};
        vt[6]  = '{3'b101, 1, 0, 1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 0};
        vt[7]  = '{3'b101, 1, 0, 1, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1};
        vt[8]  = '{3'b100, 1, 0, 1, 16'h1234, 16'h1111, 16'h0000, 16'h0000, 1};
        vt[9]  = '{3'b110, 0, 0, 0, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 0};
        vt[10] = '{3'b001, 1, 0, 1, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1};
        vt[11] = '{3'b000, 0, 1, 0, 16'h0010, 16'hFFFF, 16'h0020, 16'h0030, 0};

        // Reset with inputs that would otherwise raise StallE and PCSrcE.
        rst = 1'b1;
        set_in(3'b110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '0, '0, 5'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", StallE, 0);
        chk("rst_pcsrc", PCSrcE, 0);
        chk("rst_rw", RegWriteM, 0);
        chk("rst_mw", MemWriteM, 0);
        chk("rst_rs", ResultSrcM, 0);
        chk("rst_alu", ALUResultM, 0);
        chk("rst_wd", WriteDataM, 0);
        chk("rst_pc4", PCPlus4M, 0);
        chk("rst_rd", RDM, 0);
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) sc_vec(i);

        // Branch with a full-width PC target.
        set_in(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rep(16'hABCD), rep(16'hABCD), W'(32'h20), W'(32'h100), 5'd3);
        #3;
        chk("br_eq_pcsrc", PCSrcE, 1);
        chk("br_eq_target", PCTargetE, W'(32'h120));
        exp_q.push_back('0);
        @(posedge clk); #1;
        pop_chk("br_eq_alu");
        set_in(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rep(16'hABCD), rep(16'hABCC), W'(32'h20), W'(32'h100), 5'd3);
        #3;
        chk("br_ne_pcsrc", PCSrcE, 0);
        exp_q.push_back(rep(16'h0001));
        @(posedge clk); #1;
        pop_chk("br_ne_alu");

        run_mc("mul35", 3'b110, rep(16'h0003), rep(16'h0005), 5'd9, rep(16'h000F));
        begin
            logic [W-1:0] a3;
            for (int l = 0; l < 16; l++) a3[l*16 +: 16] = 16'(l + 1);
            run_mc("mac_taps", 3'b111, a3, rep(16'h0002), 5'd17, W'(16'h0110));
        end
        run_mc("mac_neg", 3'b111, rep(16'hFFFF), rep(16'h0100), 5'd5, W'(16'hF000));
`ifdef SATURATE_EN
        run_mc("mul_ovf", 3'b110, rep(16'h4000), rep(16'h0004), 5'd6, rep(16'h7FFF));
`else
        run_mc("mul_ovf", 3'b110, rep(16'h4000), rep(16'h0004), 5'd6, rep(16'h0000));
`endif
        ra = rnd256();
        rb = rnd256();
        for (int l = 0; l < 16; l++) rexp[l*16 +: 16] = mul_ref(ra[l*16 +: 16], rb[l*16 +: 16]);
        run_mc("mul_rnd", 3'b110, ra, rb, 5'd30, rexp);

        // Reset in the second BUSY cycle aborts the multiply.
        set_in(3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rep(16'h0003), rep(16'h0005), '0, W'(32'h40), 5'd12);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_stall", StallE, 0);
        chk("abort_rw", RegWriteM, 0);
        chk("abort_mw", MemWriteM, 0);
        chk("abort_alu", ALUResultM, 0);
        chk("abort_rd", RDM, 0);
        chk("abort_pc4", PCPlus4M, 0);
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rep(16'h0001), rep(16'h0002), '0, '0, 5'd4);
        #3;
        chk("post_rst_stall", StallE, 0);
        exp_q.push_back(rep(16'h0003));
        @(posedge clk); #1;
        pop_chk("post_rst_add");
        chk("post_rst_rw", RegWriteM, 1);
        chk("post_rst_rd", RDM, 5'd4);
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 5'd0);
        for (int k = 0; k < N + 1; k++) begin
            @(posedge clk); #1;
            chk($sformatf("no_late_result%0d", k), RegWriteM, 0);
        end
        chk("sb_empty", W'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
